ip_key_matrix: RTL and testbench

//   Key-matrix state store that answers the PPI port-B column read.
//   - Consumes key_matrix_row from the PPI mirror.
//   - Returns key_matrix_column for the selected row, active-low: 0 = key pressed.
//   - Matrix is updated from a press/release event stream (keyboard front-end)

---
 rtl/ip_key_matrix.sv | 134 +++++++++++++
 tb/tb_ip_key_matrix.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_key_matrix.sv
// ip_key_matrix: key-matrix state store answering the PPI port-B column read.
// Press/release events arrive through a small FIFO and are applied to the
// matrix by a 3-state FSM; clear_all triggers a 16-row release sweep.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting; starts a pending clear sweep or pops the FIFO head
// S_APPLY | writes the latched event into the matrix
// S_CLEAR | releases row rc, rc counts 0..15 then returns to S_IDLE
module ip_key_matrix #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_ROWS   = 11
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] key_matrix_row,
  output logic [7:0] key_matrix_column,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [3:0] ev_row,
  input  logic [2:0] ev_col,
  input  logic       ev_press,
  input  logic       clear_all,
  output logic       busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    matrix [NUM_ROWS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          clear_pending;
  logic [3:0]    rc;
  logic [3:0]    ap_row;
  logic [2:0]    ap_col;
  logic          ap_press;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          flush;
  logic [7:0]    head;

  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign ev_ready   = !fifo_full && !clear_pending && (state != S_CLEAR);
  assign push       = ev_valid && ev_ready;
  assign pop        = (state == S_IDLE) && !clear_pending && !fifo_empty;
  assign flush      = (state == S_IDLE) && clear_pending;
  assign head       = fifo_mem[rd_ptr];
  assign busy       = (state != S_IDLE) || !fifo_empty || clear_pending;

  // Event FIFO: push on handshake, pop when the FSM takes the head, flush on clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {ev_row, ev_col, ev_press};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Apply/clear FSM, owns the matrix and the pending-clear flag.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state         <= S_IDLE;
      clear_pending <= 1'b0;
      rc            <= '0;
      ap_row        <= '0;
      ap_col        <= '0;
      ap_press      <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) matrix[r] <= 8'hFF;
    end else begin
      // A pulse while pending or sweeping is absorbed.
      if (clear_all && !clear_pending && (state != S_CLEAR)) clear_pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (clear_pending) begin
            clear_pending <= 1'b0;
            rc            <= '0;
            state         <= S_CLEAR;
          end else if (!fifo_empty) begin
            {ap_row, ap_col, ap_press} <= head;
            state                      <= S_APPLY;
          end
        end
        S_APPLY: begin
          if ({1'b0, ap_row} < 5'(NUM_ROWS)) matrix[ap_row][ap_col] <= ~ap_press;
          state <= S_IDLE;
        end
        S_CLEAR: begin
          if ({1'b0, rc} < 5'(NUM_ROWS)) matrix[rc] <= 8'hFF;
          rc <= rc + 1'b1;
          if (rc == 4'hF) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered column read; unimplemented rows read as all released.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      key_matrix_column <= 8'hFF;
    end else if ({1'b0, key_matrix_row} < 5'(NUM_ROWS)) begin
      key_matrix_column <= matrix[key_matrix_row];
    end else begin
      key_matrix_column <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_ip_key_matrix.sv
// Bench for ip_key_matrix: table of single events plus hand-written
// sequences for latency, clear sweep, FIFO fill and asynchronous reset.
module tb_ip_key_matrix;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] key_matrix_row;
  logic [7:0] key_matrix_column;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_row;
  logic [2:0] ev_col;
  logic       ev_press;
  logic       clear_all;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ip_key_matrix #(.FIFO_DEPTH(4), .NUM_ROWS(11)) dut (
    .clk               (clk),
    .n_reset           (n_reset),
    .key_matrix_row    (key_matrix_row),
    .key_matrix_column (key_matrix_column),
    .ev_valid          (ev_valid),
    .ev_ready          (ev_ready),
    .ev_row            (ev_row),
    .ev_col            (ev_col),
    .ev_press          (ev_press),
    .clear_all         (clear_all),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] row;
    logic [2:0] col;
    logic       press;
    logic [3:0] sel;
    logic [7:0] exp_col;
  } vec_t;

  vec_t vecs[10];

  typedef struct {
    logic [2:0] col;
    logic       press;
  } bev_t;

  bev_t burst[8];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 200) begin
      step();
      g++;
    end
    chk1(name, busy, 1'b0);
  endtask

  // Offers one event and returns just after the accepting edge.
  task automatic send_ev(input logic [3:0] r, input logic [2:0] c, input logic p);
    int g = 0;
    ev_row   = r;
    ev_col   = c;
    ev_press = p;
    ev_valid = 1'b1;
    while (!ev_ready && g < 100) begin
      step();
      g++;
    end
    if (g >= 100) begin
      errors++;
      checks++;
      $display("FAIL send_ev timeout: ev_ready got 0 expected 1");
    end
    step();
    ev_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got 200000 expected less");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd2,  3'd1, 1'b1, 4'd2,  8'hFD};
    vecs[1] = '{4'd2,  3'd6, 1'b1, 4'd2,  8'hBD};
    vecs[2] = '{4'd2,  3'd1, 1'b1, 4'd2,  8'hBD};
    vecs[3] = '{4'd2,  3'd1, 1'b0, 4'd2,  8'hBF};
    vecs[4] = '{4'd2,  3'd0, 1'b0, 4'd2,  8'hBF};
    vecs[5] = '{4'd0,  3'd7, 1'b1, 4'd0,  8'h7F};
    vecs[6] = '{4'd10, 3'd2, 1'b1, 4'd10, 8'hFB};
    vecs[7] = '{4'd11, 3'd0, 1'b1, 4'd11, 8'hFF};
    vecs[8] = '{4'd15, 3'd3, 1'b1, 4'd15, 8'hFF};
    vecs[9] = '{4'd2,  3'd6, 1'b0, 4'd2,  8'hFF};

    burst[0] = '{3'd0, 1'b1};
    burst[1] = '{3'd0, 1'b0};
    burst[2] = '{3'd1, 1'b1};
    burst[3] = '{3'd2, 1'b1};
    burst[4] = '{3'd1, 1'b0};
    burst[5] = '{3'd3, 1'b1};
    burst[6] = '{3'd2, 1'b0};
    burst[7] = '{3'd0, 1'b1};

    n_reset        = 1'b0;
    key_matrix_row = 4'd0;
    ev_valid       = 1'b0;
    ev_row         = 4'd0;
    ev_col         = 3'd0;
    ev_press       = 1'b0;
    clear_all      = 1'b0;

    // Reset values
    #12;
    chk8("reset_column", key_matrix_column, 8'hFF);
    chk1("reset_ready", ev_ready, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    @(negedge clk);
    n_reset = 1'b1;
    step();
    chk8("row0_after_reset", key_matrix_column, 8'hFF);
    key_matrix_row = 4'd12;
    step();
    chk8("row12_column", key_matrix_column, 8'hFF);

    // Event latency: accept at N, column changes at N+3
    key_matrix_row = 4'd8;
    step();
    send_ev(4'd8, 3'd0, 1'b1);
    chk8("lat_N", key_matrix_column, 8'hFF);
    step();
    chk8("lat_N1", key_matrix_column, 8'hFF);
    step();
    chk8("lat_N2", key_matrix_column, 8'hFF);
    step();
    chk8("lat_N3", key_matrix_column, 8'hFE);
    send_ev(4'd8, 3'd0, 1'b0);
    step(3);
    chk8("release_r8", key_matrix_column, 8'hFF);
    wait_idle("idle_after_r8");

    // Table of single events
    for (int i = 0; i < 10; i++) begin
      key_matrix_row = vecs[i].sel;
      send_ev(vecs[i].row, vecs[i].col, vecs[i].press);
      wait_idle($sformatf("vec%0d_busy", i));
      step();
      chk8($sformatf("vec%0d_column", i), key_matrix_column, vecs[i].exp_col);
    end

    // Row select change 0 -> 5 follows one cycle later
    send_ev(4'd5, 3'd4, 1'b1);
    wait_idle("idle_r5");
    key_matrix_row = 4'd0;
    step();
    chk8("sel_row0", key_matrix_column, 8'h7F);
    key_matrix_row = 4'd5;
    chk8("sel_row5_before_edge", key_matrix_column, 8'h7F);
    step();
    chk8("sel_row5_after_edge", key_matrix_column, 8'hEF);

    // Clear sweep with an event held off by ev_ready, and a second absorbed pulse
    send_ev(4'd3, 3'd7, 1'b1);
    wait_idle("idle_r3");
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
    ev_row    = 4'd1;
    ev_col    = 3'd5;
    ev_press  = 1'b1;
    ev_valid  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk1($sformatf("clr_ready_%0d", k), ev_ready, 1'b0);
      chk1($sformatf("clr_busy_%0d", k), busy, 1'b1);
      if (k == 5) clear_all = 1'b1;
      step();
      clear_all = 1'b0;
    end
    chk1("clr_busy_last", busy, 1'b1);
    chk1("clr_ready_last", ev_ready, 1'b0);
    step();
    chk1("clr_busy_done", busy, 1'b0);
    chk1("clr_ready_done", ev_ready, 1'b1);
    step();
    ev_valid = 1'b0;
    wait_idle("idle_after_clear");
    key_matrix_row = 4'd3;
    step(2);
    chk8("clr_row3", key_matrix_column, 8'hFF);
    key_matrix_row = 4'd10;
    step(2);
    chk8("clr_row10", key_matrix_column, 8'hFF);
    key_matrix_row = 4'd0;
    step(2);
    chk8("clr_row0", key_matrix_column, 8'hFF);
    key_matrix_row = 4'd1;
    step(2);
    chk8("held_event_row1", key_matrix_column, 8'hDF);

    // Back-to-back burst fills the FIFO after the 7th accept, order preserved
    step();
    for (int i = 0; i < 8; i++) begin
      int g;
      g        = 0;
      ev_row   = 4'd4;
      ev_col   = burst[i].col;
      ev_press = burst[i].press;
      ev_valid = 1'b1;
      while (!ev_ready && g < 50) begin
        step();
        g++;
      end
      if (g >= 50) begin
        errors++;
        checks++;
        $display("FAIL burst_timeout_%0d: ev_ready got 0 expected 1", i);
      end
      step();
      if (i == 5) chk1("burst_ready_after6", ev_ready, 1'b1);
      if (i == 6) chk1("burst_ready_after7", ev_ready, 1'b0);
    end
    ev_valid = 1'b0;
    wait_idle("idle_after_burst");
    key_matrix_row = 4'd4;
    step(2);
    chk8("burst_row4", key_matrix_column, 8'hF6);

    // Reset mid-sweep
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
    step(5);
    #2;
    n_reset = 1'b0;
    #1;
    chk8("rst_sweep_column", key_matrix_column, 8'hFF);
    chk1("rst_sweep_ready", ev_ready, 1'b1);
    chk1("rst_sweep_busy", busy, 1'b0);
    @(negedge clk);
    n_reset = 1'b1;
    step();
    chk8("rst_sweep_row4", key_matrix_column, 8'hFF);
    chk1("rst_sweep_busy_after", busy, 1'b0);

    // Reset mid-burst: stale events must not be applied afterwards
    key_matrix_row = 4'd6;
    ev_row   = 4'd6;
    ev_col   = 3'd1;
    ev_press = 1'b1;
    ev_valid = 1'b1;
    step(3);
    #2;
    n_reset  = 1'b0;
    ev_valid = 1'b0;
    #1;
    chk8("rst_burst_column", key_matrix_column, 8'hFF);
    chk1("rst_burst_ready", ev_ready, 1'b1);
    chk1("rst_burst_busy", busy, 1'b0);
    @(negedge clk);
    n_reset = 1'b1;
    step(10);
    chk8("rst_burst_row6", key_matrix_column, 8'hFF);
    chk1("rst_burst_busy_after", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
